// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle for the two register-file write sources:
// port 0 is the ALU, port 1 is the load/store unit.
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            wb0_valid;
    logic            wb0_ready;
    logic [AW-1:0]   wb0_rd;
    logic [XLEN-1:0] wb0_data;

    logic            wb1_valid;
    logic            wb1_ready;
    logic [AW-1:0]   wb1_rd;
    logic [XLEN-1:0] wb1_data;

    modport master (
        output wb0_valid, wb0_rd, wb0_data,
        output wb1_valid, wb1_rd, wb1_data,
        input  wb0_ready, wb1_ready
    );

    modport slave (
        input  wb0_valid, wb0_rd, wb0_data,
        input  wb1_valid, wb1_rd, wb1_data,
        output wb0_ready, wb1_ready
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus the
// busy scoreboard that lets decode stall on read-after-write hazards.
module rf_wb_arbiter #(
    parameter  int XLEN = 32,
    parameter  int NREG = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  wb,
    input  logic            sb_set,
    input  logic [AW-1:0]   sb_rd,
    input  logic [AW-1:0]   chk_a1,
    input  logic [AW-1:0]   chk_a2,
    output logic            hazard,
    output logic            rf_we,
    output logic [AW-1:0]   rf_a3,
    output logic [XLEN-1:0] rf_wd
);
    logic            last_gnt;
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_nxt;
    logic            xfer;
    logic            gnt1;
    logic [AW-1:0]   gnt_rd;
    logic [XLEN-1:0] gnt_data;
    logic            pend1;
    logic            pend2;

    // A lone requester always wins; on contention the port not granted last wins.
    assign wb.wb0_ready = wb.wb0_valid && (!wb.wb1_valid || last_gnt);
    assign wb.wb1_ready = wb.wb1_valid && (!wb.wb0_valid || !last_gnt);

    assign xfer     = wb.wb0_ready || wb.wb1_ready;
    assign gnt1     = wb.wb1_ready;
    assign gnt_rd   = gnt1 ? wb.wb1_rd   : wb.wb0_rd;
    assign gnt_data = gnt1 ? wb.wb1_data : wb.wb0_data;

    // NOTE: blocking assignments in order; the later set overrides the clear,
    // so a newly issued writer keeps its register busy.
    always_comb begin
        busy_nxt = busy;
        if (rf_we)
            busy_nxt[rf_a3] = 1'b0;
        if (sb_set)
            busy_nxt[sb_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
            rf_we    <= 1'b0;
            rf_a3    <= '0;
            rf_wd    <= '0;
            busy     <= '0;
        end else begin
            busy  <= busy_nxt;
            rf_we <= xfer && (gnt_rd != '0);
            if (xfer) begin
                last_gnt <= gnt1;
                rf_a3    <= gnt_rd;
                rf_wd    <= gnt_data;
            end
        end
    end

    // The register file forwards a same-cycle write, so that register is not pending.
    assign pend1  = busy[chk_a1] && !(rf_we && (rf_a3 == chk_a1));
    assign pend2  = busy[chk_a2] && !(rf_we && (rf_a3 == chk_a2));
    assign hazard = pend1 || pend2;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: a per-cycle vector table followed by
// a hand-written mid-stream reset sequence.
module tb_rf_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sb_set = 1'b0;
    logic [4:0]  sb_rd = '0;
    logic [4:0]  chk_a1 = '0;
    logic [4:0]  chk_a2 = '0;
    logic        hazard;
    logic        rf_we;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd;

    int n_tests = 0;
    int n_fail  = 0;

    rf_wb_arbiter_if #(.XLEN(32), .AW(5)) wb ();

    rf_wb_arbiter #(.XLEN(32), .NREG(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .wb     (wb.slave),
        .sb_set (sb_set),
        .sb_rd  (sb_rd),
        .chk_a1 (chk_a1),
        .chk_a2 (chk_a2),
        .hazard (hazard),
        .rf_we  (rf_we),
        .rf_a3  (rf_a3),
        .rf_wd  (rf_wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          v0;
        logic [4:0]  rd0;
        logic [31:0] d0;
        bit          v1;
        logic [4:0]  rd1;
        logic [31:0] d1;
        bit          set;
        logic [4:0]  srd;
        logic [4:0]  a1;
        logic [4:0]  a2;
        bit          e_r0;
        bit          e_r1;
        bit          e_haz;
        bit          e_we;
        logic [4:0]  e_a3;
        logic [31:0] e_wd;
    } vec_t;

    localparam int NVEC = 27;
    vec_t vec [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        wb.wb0_valid = v.v0;
        wb.wb0_rd    = v.rd0;
        wb.wb0_data  = v.d0;
        wb.wb1_valid = v.v1;
        wb.wb1_rd    = v.rd1;
        wb.wb1_data  = v.d1;
        sb_set       = v.set;
        sb_rd        = v.srd;
        chk_a1       = v.a1;
        chk_a2       = v.a2;
    endtask

    task automatic idle();
        wb.wb0_valid = 1'b0;
        wb.wb1_valid = 1'b0;
        wb.wb0_rd    = '0;
        wb.wb1_rd    = '0;
        wb.wb0_data  = '0;
        wb.wb1_data  = '0;
        sb_set       = 1'b0;
        sb_rd        = '0;
        chk_a1       = '0;
        chk_a2       = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // v0 rd0 d0 | v1 rd1 d1 | set srd a1 a2 | r0 r1 haz we a3 wd (rf shows prior-cycle winner)
        vec[0]  = '{1, 5, 32'hAAAA_0001, 1, 6, 32'hBBBB_0002, 0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0};
        vec[1]  = '{1, 5, 32'hAAAA_0001, 1, 6, 32'hBBBB_0002, 0, 0, 0, 0,  0, 1, 0, 1, 5, 32'hAAAA_0001};
        vec[2]  = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 1, 6, 32'hBBBB_0002};
        vec[3]  = '{0, 0, 32'h0,         1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0,  0, 1, 0, 0, 0, 32'h0};
        vec[4]  = '{1, 1, 32'h11,        1, 10, 32'hA0,       0, 0, 0, 0,  1, 0, 0, 0, 0, 32'h0};
        vec[5]  = '{1, 2, 32'h22,        1, 10, 32'hA0,       0, 0, 0, 0,  0, 1, 0, 1, 1, 32'h11};
        vec[6]  = '{1, 2, 32'h22,        0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 1, 10, 32'hA0};
        vec[7]  = '{1, 3, 32'h33,        0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 1, 2, 32'h22};
        vec[8]  = '{1, 4, 32'h44,        0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 1, 3, 32'h33};
        vec[9]  = '{1, 1, 32'h0101,      0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 1, 4, 32'h44};
        vec[10] = '{1, 2, 32'h0202,      0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 1, 1, 32'h0101};
        vec[11] = '{1, 3, 32'h0303,      0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 1, 2, 32'h0202};
        vec[12] = '{1, 4, 32'h0404,      0, 0, 32'h0,         0, 0, 0, 0,  1, 0, 0, 1, 3, 32'h0303};
        vec[13] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 1, 4, 32'h0404};
        vec[14] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0};
        vec[15] = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 7, 0, 0,  0, 0, 0, 0, 0, 32'h0};
        vec[16] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 7, 0,  0, 0, 1, 0, 0, 32'h0};
        vec[17] = '{1, 7, 32'h77,        0, 0, 32'h0,         0, 0, 7, 0,  1, 0, 1, 0, 0, 32'h0};
        vec[18] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 7, 0,  0, 0, 0, 1, 7, 32'h77};
        vec[19] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 7, 0,  0, 0, 0, 0, 0, 32'h0};
        vec[20] = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 9, 0, 9,  0, 0, 0, 0, 0, 32'h0};
        vec[21] = '{0, 0, 32'h0,         1, 9, 32'h99,        0, 0, 0, 9,  0, 1, 1, 0, 0, 32'h0};
        vec[22] = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 9, 0, 9,  0, 0, 0, 1, 9, 32'h99};
        vec[23] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 9,  0, 0, 1, 0, 0, 32'h0};
        vec[24] = '{0, 0, 32'h0,         0, 0, 32'h0,         1, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0};
        vec[25] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 0, 0,  0, 0, 0, 0, 0, 32'h0};
        vec[26] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 9, 0,  0, 0, 1, 0, 0, 32'h0};

        // Power-on reset, then checks of the reset state.
        idle();
        repeat (3) @(negedge clk);
        check("reset rf_we", {31'd0, rf_we}, 32'd0);
        check("reset rf_a3", {27'd0, rf_a3}, 32'd0);
        check("reset rf_wd", rf_wd, 32'd0);
        check("reset hazard", {31'd0, hazard}, 32'd0);
        check("reset last_gnt", {31'd0, dut.last_gnt}, 32'd1);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            drive(vec[i]);
            #1;
            check($sformatf("v%0d wb0_ready", i), {31'd0, wb.wb0_ready}, {31'd0, vec[i].e_r0});
            check($sformatf("v%0d wb1_ready", i), {31'd0, wb.wb1_ready}, {31'd0, vec[i].e_r1});
            check($sformatf("v%0d hazard", i), {31'd0, hazard}, {31'd0, vec[i].e_haz});
            check($sformatf("v%0d rf_we", i), {31'd0, rf_we}, {31'd0, vec[i].e_we});
            if (vec[i].e_we) begin
                check($sformatf("v%0d rf_a3", i), {27'd0, rf_a3}, {27'd0, vec[i].e_a3});
                check($sformatf("v%0d rf_wd", i), rf_wd, vec[i].e_wd);
            end
        end

        // Mid-stream reset: build busy = 0x0F00 (bit 9 is still set) with a write in flight.
        @(negedge clk); idle(); sb_set = 1'b1; sb_rd = 5'd8;
        @(negedge clk); sb_rd = 5'd10;
        @(negedge clk); sb_rd = 5'd11;
        wb.wb0_valid = 1'b1; wb.wb0_rd = 5'd12; wb.wb0_data = 32'hC0C0_C0C0;
        @(negedge clk); idle(); chk_a1 = 5'd8;
        #1;
        check("pre-reset busy", dut.busy, 32'h0000_0F00);
        check("pre-reset rf_we", {31'd0, rf_we}, 32'd1);
        check("pre-reset rf_a3", {27'd0, rf_a3}, 32'd12);
        check("pre-reset hazard", {31'd0, hazard}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("mid reset rf_we", {31'd0, rf_we}, 32'd0);
        check("mid reset rf_a3", {27'd0, rf_a3}, 32'd0);
        check("mid reset rf_wd", rf_wd, 32'd0);
        check("mid reset busy", dut.busy, 32'd0);
        check("mid reset hazard", {31'd0, hazard}, 32'd0);
        check("mid reset last_gnt", {31'd0, dut.last_gnt}, 32'd1);
        wb.wb0_valid = 1'b1;
        wb.wb1_valid = 1'b1;
        #1;
        check("in reset wb0_ready", {31'd0, wb.wb0_ready}, 32'd1);
        check("in reset wb1_ready", {31'd0, wb.wb1_ready}, 32'd0);
        @(negedge clk); idle(); rst = 1'b0;

        // After reset, a lone ALU write goes through with one cycle of latency.
        @(negedge clk);
        wb.wb0_valid = 1'b1; wb.wb0_rd = 5'd3; wb.wb0_data = 32'h1234_5678;
        #1;
        check("post-reset wb0_ready", {31'd0, wb.wb0_ready}, 32'd1);
        @(negedge clk); idle();
        #1;
        check("post-reset rf_we", {31'd0, rf_we}, 32'd1);
        check("post-reset rf_a3", {27'd0, rf_a3}, 32'd3);
        check("post-reset rf_wd", rf_wd, 32'h1234_5678);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and scoreboard for the 32×32 register file, which has one write port. Two write-back sources share that port under a round-robin valid/ready handshake: port 0 is the ALU and port 1 is the load/store unit. The block registers the winning write onto the register-file write port. It also keeps a per-register busy scoreboard so the decode stage can stall on read-after-write hazards.

## Interface
- `XLEN`, 32, data width of the write-back path.
- `NREG`, 32, number of architectural registers. Register addresses are `$clog2(NREG)` = 5 bits.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `wb0_valid` input 1: ALU write-back request.
- `wb0_ready` output 1: ALU request accepted this cycle.
- `wb0_rd` input 5: ALU destination register.
- `wb0_data` input XLEN: ALU result.
- `wb1_valid`, `wb1_ready`, `wb1_rd`, `wb1_data`: the same four signals for the LSU.
- `sb_set` input 1: decode issues an instruction that writes `sb_rd`.
- `sb_rd` input 5: destination register to mark busy.
- `chk_a1` input 5: decode read address for operand 1.
- `chk_a2` input 5: decode read address for operand 2.
- `hazard` output 1: at least one decode operand is pending, so decode must stall.
- `rf_we` output 1: register-file write enable. Registered.
- `rf_a3` output 5: register-file write address. Registered.
- `rf_wd` output XLEN: register-file write data. Registered.

## Operation
- **Handshake**
  - A request transfers in the cycle where `wbN_valid` and `wbN_ready` are both high.
  - `wbN_ready` is combinational from the valids and the round-robin pointer.
  - A source holds `valid`, `rd` and `data` stable until the transfer completes.
- **Arbitration**
  - One transfer per cycle at most.
  - Only one source valid: that source is granted.
  - Both sources valid: the source not granted last is granted.
  - `last_gnt` is a 1-bit register. It updates only on a transfer and stores the index of the granted source.
  - Reset value of `last_gnt` is 1, so port 0 wins the first contested cycle.
  - A starved source waits at most one cycle while contending.
- **Output stage**
  - On a transfer: next-cycle `rf_we`=1, `rf_a3`=granted rd, `rf_wd`=granted data.
  - No transfer: next-cycle `rf_we`=0. `rf_a3` and `rf_wd` hold their previous values.
  - A transfer with rd=0 is accepted but produces `rf_we`=0. It still updates `last_gnt`.
- **Scoreboard**
  - `busy` is a NREG-bit register.
  - An `sb_set` with `sb_rd`≠0 sets `busy[sb_rd]`.
  - A cycle with `rf_we`=1 clears `busy[rf_a3]` at the end of that cycle.
  - Set and clear of the same register in the same cycle: set wins, because a new write is in flight.
  - `busy[0]` is always 0.
  - Issue rule: each issued instruction sets the register busy once. A second in-flight writer to the same register is not tracked, and decode guarantees it does not occur.
- **Hazard**
  - A register is pending when `busy[a]`=1 and it is not being written this cycle (`rf_we`=1 and `rf_a3`=a).
  - The register file forwards `wd` on a same-cycle write, so a register being written is not pending.
  - `hazard` = pending(`chk_a1`) OR pending(`chk_a2`). Address 0 never raises `hazard`.

## Timing
- **Reset (asynchronous, effective immediately):**
  - `rf_we`=0, `rf_a3`=0, `rf_wd`=0.
  - `busy`=0 and `hazard`=0.
  - `last_gnt`=1.
  - `wbN_ready` follows the valids combinationally, including while reset is asserted.
- **Reset asserted mid-operation:**
  - Any pending output write is dropped and the scoreboard clears.
  - Sources must re-present their requests after reset.
- **Latency:**
  - Transfer in cycle T gives `rf_we` in cycle T+1, with the register-file write at the end of T+1.
  - The busy bit clears at the end of T+1.
  - `hazard` drops combinationally in T+1 for that register.
- **Throughput:** one write per cycle sustained. Back-to-back transfers from the same or alternating sources are allowed.
- **Combinational paths:**
  - valids → readys.
  - `chk_a1`, `chk_a2`, `rf_we`, `rf_a3`, `busy` → `hazard`.
  - No combinational path from valids to `rf_*`.

## Test plan
- **Reset values:** assert `rst` mid-stream with `busy`=0x0000_0F00 and `rf_we`=1 → immediately all outputs are 0, `busy`=0, and `last_gnt`=1.
- **Contention:** `wb0` is (rd=5, 0xAAAA_0001) and `wb1` is (rd=6, 0xBBBB_0002), both valid for 2 cycles.
  - Cycle 0: `wb0_ready`=1, `wb1_ready`=0.
  - Cycle 1: `wb1_ready`=1.
  - `rf` sees (5, 0xAAAA_0001), then (6, 0xBBBB_0002).
- **x0 write:** `wb1` transfers rd=0, data 0xDEAD_BEEF → `wb1_ready`=1, next-cycle `rf_we`=0, `last_gnt`=1.
- **Scoreboard hazard:**
  - `sb_set` rd=7, then `chk_a1`=7 → `hazard`=1.
  - ALU transfers rd=7 in T → `hazard`=0 in T+1, and `busy[7]`=0 from T+2.
- **Set/clear collision:** `rf_we`=1 with `rf_a3`=9 in the same cycle as `sb_set` with `sb_rd`=9 → `busy[9]` remains 1 and `hazard` for `chk_a2`=9 is 1 in the next cycle.
- **Throughput:** only `wb0` valid for 4 cycles with rd 1..4 → `wb0_ready`=1 each cycle and `rf_we`=1 for 4 consecutive cycles, one cycle later, with matching addresses.
